vga_timing_gen: RTL and testbench

Parametrised VGA/LCD raster timing generator, the successor to the fixed 640x480 sync core. It generates per-axis counters, sync and blanking, and a linear pixel address for any timing set given by parameters, with programmable sync polarity. It advances on a pixel-rate strobe inside the system clock domain, so no second clock is needed. A lead-fetch port runs LEAD pixels ahead of display to hide frame-buffer read latency. It sits between the clock/strobe divider and the VGA pixel pipeline / frame-buffer reader.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_timing_if.sv | 40 ++++
 rtl/vga_axis_cnt.sv | 53 +++++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Holds the standard 640x480 and 800x600 timing sets.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    function automatic int axis_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster position / sync / fetch bundle from the timing generator
// to the pixel pipeline and frame-buffer reader.
interface vga_timing_if #(
    parameter int CW = 11,
    parameter int PW = 21
);
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic [PW-1:0] p_count;
    logic          vga_valid;
    logic          h_en;
    logic          v_en;
    logic          h_sync;
    logic          v_sync;
    logic          line_start;
    logic          frame_start;
    logic          fetch_en;
    logic [PW-1:0] fetch_addr;
    logic [CW-1:0] h_disp_max;
    logic [CW-1:0] v_disp_max;
    logic [PW-1:0] p_disp_max;

    modport master (
        output h_count, v_count, p_count,
        output vga_valid, h_en, v_en,
        output h_sync, v_sync,
        output line_start, frame_start,
        output fetch_en, fetch_addr,
        output h_disp_max, v_disp_max, p_disp_max
    );

    modport slave (
        input h_count, v_count, p_count,
        input vga_valid, h_en, v_en,
        input h_sync, v_sync,
        input line_start, frame_start,
        input fetch_en, fetch_addr,
        input h_disp_max, v_disp_max, p_disp_max
    );
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter with registered active/sync decode.
// 'last' is the carry used to step the next axis.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 11,
    parameter int INIT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          en,
    output logic          sync,
    output logic          last,
    output logic          en_nxt
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int S0    = ACTIVE + FP;
    localparam int S1    = S0 + SYNC;

    logic [CW-1:0] cnt_nxt;

    function automatic logic sync_lvl(input logic [CW-1:0] c);
        return (c >= CW'(S0) && c < CW'(S1)) ? POL : !POL;
    endfunction

    always_comb begin
        last    = (cnt == CW'(TOTAL - 1));
        cnt_nxt = cnt;
        if (step) cnt_nxt = last ? '0 : cnt + 1'b1;
        en_nxt  = (cnt_nxt < CW'(ACTIVE));
    end

    // Decodes are registered from the next count so they align with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= CW'(INIT);
            en   <= (INIT < ACTIVE);
            sync <= sync_lvl(CW'(INIT));
        end else begin
            cnt  <= cnt_nxt;
            en   <= en_nxt;
            sync <= sync_lvl(cnt_nxt);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator on a pixel strobe, with a
// lead-fetch position running LEAD pixels ahead of display.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int LEAD     = 0,
    parameter int CW       = 11,
    parameter int PW       = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
    vga_timing_if.master vif
);
    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int N_POS    = H_TOTAL * V_TOTAL;
    localparam int LEAD_LIN = (N_POS - 1 + LEAD) % N_POS;
    localparam int LH_INIT  = LEAD_LIN % H_TOTAL;
    localparam int LV_INIT  = LEAD_LIN / H_TOTAL;
    // Lead starts on line 0 at LEAD-1; in blanking it holds the line's last address.
    localparam int F_INIT   = (LEAD == 0) ? 0 :
                              (LEAD - 1 < H_ACTIVE) ? LEAD - 1 : H_ACTIVE - 1;

    if (LEAD < 0 || LEAD > H_TOTAL - H_ACTIVE) begin : g_bad_lead
        $error("vga_timing_gen: LEAD out of range");
    end
    if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for totals");
    end
    if (H_ACTIVE * V_ACTIVE > 2 ** PW) begin : g_bad_pw
        $error("vga_timing_gen: PW too narrow for frame");
    end

    logic [CW-1:0] h_cnt, v_cnt, lh_cnt, lv_cnt;
    logic          h_en, v_en, lh_en, lv_en;
    logic          h_sync, v_sync, lh_sync, lv_sync;
    logic          h_last, v_last, lh_last, lv_last;
    logic          h_en_n, v_en_n, lh_en_n, lv_en_n;
    logic [PW-1:0] p_cnt, f_addr;
    logic          valid, f_en, l_start, f_start;
    logic          unused_lead;

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(H_POL), .CW(CW), .INIT(H_TOTAL - 1)
    ) u_h (
        .clk, .rst, .step(pix_en),
        .cnt(h_cnt), .en(h_en), .sync(h_sync),
        .last(h_last), .en_nxt(h_en_n)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(V_POL), .CW(CW), .INIT(V_TOTAL - 1)
    ) u_v (
        .clk, .rst, .step(pix_en & h_last),
        .cnt(v_cnt), .en(v_en), .sync(v_sync),
        .last(v_last), .en_nxt(v_en_n)
    );

    vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(H_POL), .CW(CW), .INIT(LH_INIT)
    ) u_lh (
        .clk, .rst, .step(pix_en),
        .cnt(lh_cnt), .en(lh_en), .sync(lh_sync),
        .last(lh_last), .en_nxt(lh_en_n)
    );

    vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(V_POL), .CW(CW), .INIT(LV_INIT)
    ) u_lv (
        .clk, .rst, .step(pix_en & lh_last),
        .cnt(lv_cnt), .en(lv_en), .sync(lv_sync),
        .last(lv_last), .en_nxt(lv_en_n)
    );

    assign unused_lead = ^{lh_cnt, lv_cnt, lh_en, lv_en, lh_sync, lv_sync};

    function automatic logic [PW-1:0] addr_step(
        input logic [PW-1:0] a,
        input logic          step,
        input logic          wrap,
        input logic          act
    );
        if (!step) return a;
        if (wrap)  return '0;
        if (act)   return a + 1'b1;
        return a;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_cnt   <= '0;
            f_addr  <= PW'(F_INIT);
            valid   <= 1'b0;
            f_en    <= (LH_INIT < H_ACTIVE) && (LV_INIT < V_ACTIVE);
            l_start <= 1'b0;
            f_start <= 1'b0;
        end else begin
            valid   <= h_en_n & v_en_n;
            f_en    <= lh_en_n & lv_en_n;
            l_start <= pix_en & h_last;
            f_start <= pix_en & h_last & v_last;
            p_cnt   <= addr_step(p_cnt, pix_en,
                                 h_last & v_last, h_en_n & v_en_n);
            f_addr  <= addr_step(f_addr, pix_en,
                                 lh_last & lv_last, lh_en_n & lv_en_n);
        end
    end

    assign vif.h_count     = h_cnt;
    assign vif.v_count     = v_cnt;
    assign vif.p_count     = p_cnt;
    assign vif.vga_valid   = valid;
    assign vif.h_en        = h_en;
    assign vif.v_en        = v_en;
    assign vif.h_sync      = h_sync;
    assign vif.v_sync      = v_sync;
    assign vif.line_start  = l_start;
    assign vif.frame_start = f_start;
    assign vif.fetch_en    = f_en;
    assign vif.fetch_addr  = f_addr;
    assign vif.h_disp_max  = CW'(H_ACTIVE - 1);
    assign vif.v_disp_max  = CW'(V_ACTIVE - 1);
    assign vif.p_disp_max  = PW'(H_ACTIVE * V_ACTIVE - 1);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: frame-level position model checked every
// cycle on two instances (LEAD=2 low-polarity, LEAD=0 high-polarity).
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 16, VT = 8, NPOS = HT * VT;
    localparam int LD = 2;
    localparam int CW = 6, PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if #(.CW(CW), .PW(PW)) bus ();
    vga_timing_if #(.CW(CW), .PW(PW)) bus_p ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .LEAD(LD), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vif(bus)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .LEAD(0), .CW(CW), .PW(PW)
    ) dut_p (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vif(bus_p)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m;
    bit fresh;
    bit adv;
    bit chk_on = 1'b0;

    // Model: linear raster position; fresh = no advance since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = NPOS - 1;
            fresh = 1'b1;
            adv = 1'b0;
        end else begin
            adv = pix_en;
            if (pix_en) begin
                m = (m + 1) % NPOS;
                fresh = 1'b0;
            end
        end
    end

    function automatic int addr_of(input int pos);
        int h, v;
        h = pos % HT;
        v = pos / HT;
        if (v >= VA) return HA * VA - 1;
        return v * HA + ((h < HA) ? h : HA - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_dut(
        input string t, input int L, input bit hp, input bit vp,
        input logic [CW-1:0] hc, input logic [CW-1:0] vc,
        input logic [PW-1:0] pc, input logic val,
        input logic he, input logic ve, input logic hs, input logic vs,
        input logic ls, input logic fs, input logic fe,
        input logic [PW-1:0] fa, input logic [CW-1:0] hm,
        input logic [CW-1:0] vm, input logic [PW-1:0] pm
    );
        int h, v, lp;
        h = m % HT;
        v = m / HT;
        lp = (m + L) % NPOS;
        chk({t, ".h_count"}, hc, h);
        chk({t, ".v_count"}, vc, v);
        chk({t, ".p_count"}, pc, fresh ? 0 : addr_of(m));
        chk({t, ".vga_valid"}, val, int'(h < HA && v < VA));
        chk({t, ".h_en"}, he, int'(h < HA));
        chk({t, ".v_en"}, ve, int'(v < VA));
        chk({t, ".h_sync"}, hs, (h >= 10 && h < 13) ? hp : !hp);
        chk({t, ".v_sync"}, vs, (v >= 5 && v < 7) ? vp : !vp);
        chk({t, ".line_start"}, ls, int'(adv && h == 0));
        chk({t, ".frame_start"}, fs, int'(adv && m == 0));
        chk({t, ".fetch_en"}, fe, int'(lp % HT < HA && lp / HT < VA));
        chk({t, ".fetch_addr"}, fa,
            (fresh && L == 0) ? 0 : addr_of(lp));
        chk({t, ".h_disp_max"}, hm, HA - 1);
        chk({t, ".v_disp_max"}, vm, VA - 1);
        chk({t, ".p_disp_max"}, pm, HA * VA - 1);
    endtask

    always @(negedge clk) begin
        if (!rst && chk_on) begin
            cmp_dut("lead2", LD, 1'b0, 1'b0,
                bus.h_count, bus.v_count, bus.p_count, bus.vga_valid,
                bus.h_en, bus.v_en, bus.h_sync, bus.v_sync,
                bus.line_start, bus.frame_start, bus.fetch_en,
                bus.fetch_addr, bus.h_disp_max, bus.v_disp_max,
                bus.p_disp_max);
            cmp_dut("pol1", 0, 1'b1, 1'b1,
                bus_p.h_count, bus_p.v_count, bus_p.p_count,
                bus_p.vga_valid, bus_p.h_en, bus_p.v_en,
                bus_p.h_sync, bus_p.v_sync, bus_p.line_start,
                bus_p.frame_start, bus_p.fetch_en, bus_p.fetch_addr,
                bus_p.h_disp_max, bus_p.v_disp_max, bus_p.p_disp_max);
        end
    end

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".h_count"}, bus.h_count, 15);
        chk({t, ".v_count"}, bus.v_count, 7);
        chk({t, ".p_count"}, bus.p_count, 0);
        chk({t, ".vga_valid"}, bus.vga_valid, 0);
        chk({t, ".line_start"}, bus.line_start, 0);
        chk({t, ".frame_start"}, bus.frame_start, 0);
        chk({t, ".h_sync"}, bus.h_sync, 1);
        chk({t, ".v_sync"}, bus.v_sync, 1);
        chk({t, ".fetch_en"}, bus.fetch_en, 1);
        chk({t, ".fetch_addr"}, bus.fetch_addr, 1);
        chk({t, ".pol_h_sync"}, bus_p.h_sync, 0);
        chk({t, ".pol_v_sync"}, bus_p.v_sync, 0);
        chk({t, ".pol_fetch_addr"}, bus_p.fetch_addr, 0);
    endtask

    initial begin
        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        pix_en = 1'b1;
        edge_n(1);
        chk("first.h", bus.h_count, 0);
        chk("first.v", bus.v_count, 0);
        chk("first.p", bus.p_count, 0);
        chk("first.valid", bus.vga_valid, 1);
        chk("first.fs", bus.frame_start, 1);
        chk("first.ls", bus.line_start, 1);
        chk("first.fetch_addr", bus.fetch_addr, 2);
        edge_n(8);
        chk("h8.h", bus.h_count, 8);
        chk("h8.p", bus.p_count, 7);
        chk("h8.h_en", bus.h_en, 0);
        edge_n(8);
        chk("v1.v", bus.v_count, 1);
        chk("v1.p", bus.p_count, 8);
        chk("v1.ls", bus.line_start, 1);
        chk("v1.fs", bus.frame_start, 0);
        edge_n(110);
        chk("e14_7.h", bus.h_count, 14);
        chk("e14_7.v", bus.v_count, 7);
        chk("e14_7.fetch_en", bus.fetch_en, 1);
        chk("e14_7.fetch_addr", bus.fetch_addr, 0);
        edge_n(2);
        chk("wrap.h", bus.h_count, 0);
        chk("wrap.v", bus.v_count, 0);
        chk("wrap.fs", bus.frame_start, 1);
        chk("wrap.p", bus.p_count, 0);
        edge_n(1);
        chk("tog.h1", bus.h_count, 1);
        pix_en = 1'b0;
        edge_n(1);
        chk("hold1.h", bus.h_count, 1);
        chk("hold1.ls", bus.line_start, 0);
        edge_n(1);
        chk("hold2.h", bus.h_count, 1);
        chk("hold2.p", bus.p_count, 1);
        pix_en = 1'b1;
        edge_n(1);
        chk("resume.h", bus.h_count, 2);
        chk("resume.p", bus.p_count, 2);
        for (int i = 0; i < 200 && m != 2 * HT + 5; i++) edge_n(1);
        chk("at5_2.h", bus.h_count, 5);
        chk("at5_2.v", bus.v_count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async");
        edge_n(2);
        @(negedge clk);
        rst = 1'b0;
        edge_n(1);
        chk("rel.h", bus.h_count, 0);
        chk("rel.fs", bus.frame_start, 1);
        chk("rel.ls", bus.line_start, 1);
        repeat (400) begin
            pix_en = 1'($urandom_range(0, 1));
            edge_n(1);
        end
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
